// File: rtl/bcd_field_extensor_seq_pkg.sv
// Shared definitions for the digit field extender: mode encodings, fill
// digits and FSM state codes.
package bcd_field_extensor_seq_pkg;

    localparam logic MODE_BCD = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    localparam logic [3:0] FILL_POS     = 4'h0;
    localparam logic [3:0] FILL_BCD_NEG = 4'h9;
    localparam logic [3:0] FILL_HEX_NEG = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_field_extensor_seq_classifier.sv
// Combinational classification of one 4-bit digit: the fill digit it implies
// when it is the most significant digit, and whether it is illegal in BCD.
module digit_sign_classifier
    import bcd_field_extensor_seq_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] fill,
    output logic       bad
);

    // BCD: 0-4 positive, 5-9 negative (10's complement), 10-15 illegal and
    // treated as positive. HEX: the top bit of the nibble is the sign.
    always_comb begin
        fill = FILL_POS;
        bad  = 1'b0;
        if (mode == MODE_HEX) begin
            if (digit[3]) begin
                fill = FILL_HEX_NEG;
            end
        end else begin
            if (digit > 4'd9) begin
                bad = 1'b1;
            end else if (digit >= 4'd5) begin
                fill = FILL_BCD_NEG;
            end
        end
    end

endmodule

// File: rtl/bcd_field_extensor_seq.sv
// Sequential sign extender for N_IN-digit signed words (BCD 10's complement or
// HEX 2's complement) to N_OUT digits. Copies one digit per cycle LSD first,
// resolves the fill digit from the MSD, then writes the fill digits one per
// cycle and presents the result through a valid/ready handshake.
module bcd_field_extensor_seq
    import bcd_field_extensor_seq_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 8
) (
    input  logic               clock,
    input  logic               reset_,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [4*N_IN-1:0]  x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*N_OUT-1:0] x_est,
    output logic               sign,
    output logic               err
);

    localparam int CW     = $clog2(N_OUT) + 1;
    localparam int IW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int IW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0] LAST_IN  = CW'(N_IN - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);
    localparam logic [CW-1:0] N_OUT_C  = CW'(N_OUT);

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N_IN-1:0][3:0]       x_hold_q, x_hold_d;
    logic                       mode_q, mode_d;
    logic [N_OUT-1:0][3:0]      x_est_q, x_est_d;
    logic [3:0]                 fill_q, fill_d;
    logic                       sign_q, sign_d;
    logic                       err_q, err_d;

    logic [IW_IN-1:0]           idx_in;
    logic [IW_OUT-1:0]          idx_out;
    logic [3:0]                 cur_digit;
    logic [3:0]                 cls_fill;
    logic                       cls_bad;
    logic                       is_msd;

    assign idx_in    = cnt_q[IW_IN-1:0];
    assign idx_out   = cnt_q[IW_OUT-1:0];
    assign cur_digit = x_hold_q[idx_in];
    assign is_msd    = (cnt_q == LAST_IN);

    digit_sign_classifier u_classifier (
        .digit (cur_digit),
        .mode  (mode_q),
        .fill  (cls_fill),
        .bad   (cls_bad)
    );

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_hold_q <= '0;
            mode_q   <= MODE_BCD;
            x_est_q  <= '0;
            fill_q   <= FILL_POS;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_hold_q <= x_hold_d;
            mode_q   <= mode_d;
            x_est_q  <= x_est_d;
            fill_q   <= fill_d;
            sign_q   <= sign_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: the digit counter alone decides when CHECK and FILL end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = CHECK;
            CHECK: if (is_msd) state_d = (N_OUT > N_IN) ? FILL : DONE;
            FILL:  if (cnt_q == LAST_OUT) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: latch at accept, copy digits in CHECK, fill in FILL.
    always_comb begin
        cnt_d    = cnt_q;
        x_hold_d = x_hold_q;
        mode_d   = mode_q;
        x_est_d  = x_est_q;
        fill_d   = fill_q;
        sign_d   = sign_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_hold_d = x;
                    mode_d   = mode;
                    err_d    = 1'b0;
                    sign_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            CHECK: begin
                x_est_d[idx_out] = cur_digit;
                if (cls_bad) begin
                    err_d = 1'b1;
                end
                if (is_msd) begin
                    fill_d = cls_fill;
                    sign_d = (cls_fill != FILL_POS);
                end
                cnt_d = cnt_q + 1'b1;
            end
            FILL: begin
                x_est_d[idx_out] = fill_q;
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign x_est = x_est_q;
    assign sign  = sign_q;
    assign err   = err_q;

    // Digit writes happen only in CHECK and FILL and must stay inside x_est.
    always @(posedge clock) begin
        if (reset_ && (state_q == CHECK || state_q == FILL)) begin
            assert (cnt_q < N_OUT_C);
        end
    end

endmodule

// File: tb/tb_bcd_field_extensor_seq.sv
// Self-checking bench for bcd_field_extensor_seq (N_IN=4, N_OUT=8): directed
// cases plus randomized words against a value-level reference model.
module tb_bcd_field_extensor_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 8;

    typedef struct packed {
        logic        err;
        logic        sign;
        logic [31:0] est;
    } res_t;

    logic        clock;
    logic        reset_;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_est;
    logic        sign;
    logic        err;

    int tests_run;
    int tests_failed;

    bcd_field_extensor_seq #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_est     (x_est),
        .sign      (sign),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the value as a signed number widened to 8 digits.
    function automatic res_t model(input logic [15:0] xv, input logic m);
        res_t r;
        int   msd;
        r.err = 1'b0;
        if (m) begin
            r.est  = 32'($signed(xv));
            r.sign = xv[15];
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (((xv >> (4 * i)) & 16'hF) > 9) r.err = 1'b1;
            end
            msd    = int'(xv >> 12);
            r.sign = (msd >= 5) && (msd <= 9);
            r.est  = r.sign ? (32'h9999_0000 | 32'(xv)) : 32'(xv);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges after an accept edge until out_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic check_result(input string tag, input res_t e);
        check({tag, "_x_est"}, 64'(x_est), 64'(e.est));
        check({tag, "_sign"},  64'(sign),  64'(e.sign));
        check({tag, "_err"},   64'(err),   64'(e.err));
    endtask

    task automatic run_txn(input string tag, input logic [15:0] xv, input logic m, input int hold);
        res_t e;
        int   lat;
        e = model(xv, m);
        wait_ready(tag);
        in_valid = 1'b1;
        x        = xv;
        mode     = m;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x        = 16'($urandom);
        mode     = 1'($urandom);
        wait_result(lat);
        check({tag, "_latency"}, 64'(lat), 64'(N_OUT));
        check_result(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_hold_x_est"}, 64'(x_est), 64'(e.est));
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_back_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        res_t ea, eb;
        int   lat;
        logic [15:0] rx;
        logic        rm;

        tests_run    = 0;
        tests_failed = 0;
        reset_    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        x         = '0;

        // Reset state
        #12;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_x_est",     64'(x_est),     64'(0));
        check("rst_sign",      64'(sign),      64'(0));
        check("rst_err",       64'(err),       64'(0));
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);

        // Directed cases
        run_txn("bcd_0042", 16'h0042, 1'b0, 0);
        run_txn("bcd_5123", 16'h5123, 1'b0, 0);
        run_txn("bcd_4999", 16'h4999, 1'b0, 1);
        run_txn("bcd_9000", 16'h9000, 1'b0, 0);
        run_txn("bcd_12A4", 16'h12A4, 1'b0, 0);
        run_txn("bcd_C000", 16'hC000, 1'b0, 0);
        run_txn("hex_8001", 16'h8001, 1'b1, 0);
        run_txn("hex_7FFF", 16'h7FFF, 1'b1, 0);
        run_txn("hex_FA00", 16'hFA00, 1'b1, 2);

        // Backpressure with in_valid held high across two words
        ea = model(16'h5678, 1'b0);
        eb = model(16'hF123, 1'b1);
        wait_ready("bp_a");
        in_valid = 1'b1;
        x        = 16'h5678;
        mode     = 1'b0;
        @(posedge clock);
        #1;
        x    = 16'hF123;
        mode = 1'b1;
        wait_result(lat);
        check("bp_a_latency", 64'(lat), 64'(N_OUT));
        check_result("bp_a", ea);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("bp_stall_valid", 64'(out_valid), 64'(1));
            check("bp_stall_x_est", 64'(x_est), 64'(ea.est));
            check("bp_stall_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("bp_idle_ready", 64'(in_ready), 64'(1));
        check("bp_idle_valid", 64'(out_valid), 64'(0));
        check("bp_idle_x_est", 64'(x_est), 64'(ea.est));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("bp_b_accepted", 64'(in_ready), 64'(0));
        wait_result(lat);
        check("bp_b_latency", 64'(lat), 64'(N_OUT));
        check_result("bp_b", eb);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset during the second CHECK cycle
        wait_ready("mid_rst");
        in_valid = 1'b1;
        x        = 16'h5123;
        mode     = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_ = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(in_ready),  64'(1));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_x_est",     64'(x_est),     64'(0));
        check("mid_rst_sign",      64'(sign),      64'(0));
        check("mid_rst_err",       64'(err),       64'(0));
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        run_txn("post_rst_0007", 16'h0007, 1'b0, 0);

        // Randomized words, half of BCD ones restricted to legal digits
        for (int t = 0; t < 30; t++) begin
            rm = 1'($urandom);
            rx = 16'($urandom);
            if (!rm && $urandom_range(0, 1) == 1) begin
                for (int d = 0; d < N_IN; d++) begin
                    rx[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end
            run_txn("rand", rx, rm, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
